// File: rtl/kmeans_scheduler.sv
// Per-frame sequencer for the k_means centroid tracker: reset, seed, frame-align, compute, publish.
// Latency: publish lands 1 cycle after km_valid_in; km_new_frame_out is combinational from new_frame_in.
// Backpressure: none; frame strobes arriving while clustering are dropped and counted (KMEANS_SCHED_STATS_EN).
module kmeans_scheduler #(
  parameter int WIDTH           = 320,
  parameter int HEIGHT          = 180,
  parameter int COMPUTE_TIMEOUT = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        new_frame_in,
  input  logic [2:0]  num_balls_in,
  input  logic [8:0]  seed_x_in [6:0],
  input  logic [7:0]  seed_y_in [6:0],
  input  logic        km_valid_in,
  input  logic [8:0]  km_x_in [6:0],
  input  logic [7:0]  km_y_in [6:0],
  output logic        km_rst_out,
  output logic        km_new_frame_out,
  output logic [2:0]  km_num_balls_out,
  output logic [8:0]  km_seed_x_out [6:0],
  output logic [7:0]  km_seed_y_out [6:0],
  output logic [8:0]  centroids_x_out [6:0],
  output logic [7:0]  centroids_y_out [6:0],
  output logic        centroids_valid_out,
  output logic        timeout_out,
  output logic [15:0] drop_count_out,
  output logic [23:0] compute_cycles_out
);

  // Bounds are widened by one bit so a parameter equal to the field range still compares correctly.
  localparam logic [9:0]  WIDTH_L  = 10'(WIDTH);
  localparam logic [8:0]  HEIGHT_L = 9'(HEIGHT);
  localparam logic [23:0] TMO_LAST = 24'(COMPUTE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KM_RST,
    S_SYNC,
    S_STORE,
    S_COMPUTE
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        force_seed_q, force_seed_d;
  logic [2:0]  num_balls_q, num_balls_d;
  logic        valid_q, valid_d;
  logic [8:0]  seed_x_q [6:0];
  logic [7:0]  seed_y_q [6:0];
  logic [8:0]  seed_x_d [6:0];
  logic [7:0]  seed_y_d [6:0];
  logic [8:0]  cent_x_q [6:0];
  logic [7:0]  cent_y_q [6:0];
  logic [8:0]  cent_x_d [6:0];
  logic [7:0]  cent_y_d [6:0];

  logic in_compute;
  logic publish;
  logic tmo_hit;
  logic use_default_seed;

  // A result in the final allowed cycle wins over the timeout.
  assign in_compute       = (state_q == S_COMPUTE);
  assign publish          = in_compute & km_valid_in;
  assign tmo_hit          = in_compute & ~km_valid_in & (cnt_q == TMO_LAST);
  assign use_default_seed = force_seed_q | (num_balls_q != num_balls_in);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode plus k_means reset and gated frame strobe.
  always_comb begin
    state_d          = state_q;
    km_rst_out       = 1'b0;
    km_new_frame_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        km_rst_out = 1'b1;
        if (enable_in) state_d = S_KM_RST;
      end
      S_KM_RST: begin
        km_rst_out = 1'b1;
        state_d    = S_SYNC;
      end
      S_SYNC: begin
        if (!enable_in)        state_d = S_IDLE;
        else if (new_frame_in) state_d = S_STORE;
      end
      S_STORE: begin
        // Mask storage now holds a full frame; the next boundary starts clustering.
        km_new_frame_out = new_frame_in;
        if (new_frame_in) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (km_valid_in) state_d = enable_in ? S_KM_RST : S_IDLE;
        else if (tmo_hit) state_d = S_KM_RST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Compute-cycle counter, status flags and ball-count latch next values.
  always_comb begin
    cnt_d        = in_compute ? (cnt_q + 24'd1) : 24'd0;
    timeout_d    = timeout_q | tmo_hit;
    force_seed_d = force_seed_q;
    num_balls_d  = num_balls_q;
    valid_d      = publish;
    if (tmo_hit) force_seed_d = 1'b1;
    if (state_q == S_KM_RST) begin
      force_seed_d = 1'b0;
      num_balls_d  = num_balls_in;
    end
  end

  // Control registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q        <= 24'd0;
      timeout_q    <= 1'b0;
      force_seed_q <= 1'b1;
      num_balls_q  <= 3'd0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      force_seed_q <= force_seed_d;
      num_balls_q  <= num_balls_d;
      valid_q      <= valid_d;
    end
  end

  // Seeds change only in KM_RST: defaults after reset/timeout/ball-count change, else last published.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      seed_x_d[i] = seed_x_q[i];
      seed_y_d[i] = seed_y_q[i];
      if (state_q == S_KM_RST) begin
        seed_x_d[i] = use_default_seed ? seed_x_in[i] : cent_x_q[i];
        seed_y_d[i] = use_default_seed ? seed_y_in[i] : cent_y_q[i];
      end
    end
  end

  // Seed registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 7; i++) begin
        seed_x_q[i] <= 9'd0;
        seed_y_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        seed_x_q[i] <= seed_x_d[i];
        seed_y_q[i] <= seed_y_d[i];
      end
    end
  end

  // Publish filter: out-of-frame results (e.g. empty-cluster divide) keep the previous centroid.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      cent_x_d[i] = cent_x_q[i];
      cent_y_d[i] = cent_y_q[i];
      if (publish) begin
        if (3'(i) >= num_balls_q) begin
          cent_x_d[i] = 9'd0;
          cent_y_d[i] = 8'd0;
        end else if (({1'b0, km_x_in[i]} < WIDTH_L) && ({1'b0, km_y_in[i]} < HEIGHT_L)) begin
          cent_x_d[i] = km_x_in[i];
          cent_y_d[i] = km_y_in[i];
        end
      end
    end
  end

  // Published centroid registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 7; i++) begin
        cent_x_q[i] <= 9'd0;
        cent_y_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        cent_x_q[i] <= cent_x_d[i];
        cent_y_q[i] <= cent_y_d[i];
      end
    end
  end

`ifdef KMEANS_SCHED_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [23:0] cycles_q, cycles_d;

  // Frames lost while clustering (saturating) and duration of the last successful compute.
  always_comb begin
    drop_d   = drop_q;
    cycles_d = cycles_q;
    if (in_compute && new_frame_in && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (publish) cycles_d = cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_q   <= 16'd0;
      cycles_q <= 24'd0;
    end else begin
      drop_q   <= drop_d;
      cycles_q <= cycles_d;
    end
  end

  assign drop_count_out     = drop_q;
  assign compute_cycles_out = cycles_q;
`else
  assign drop_count_out     = 16'd0;
  assign compute_cycles_out = 24'd0;
`endif

  assign km_num_balls_out    = num_balls_q;
  assign km_seed_x_out       = seed_x_q;
  assign km_seed_y_out       = seed_y_q;
  assign centroids_x_out     = cent_x_q;
  assign centroids_y_out     = cent_y_q;
  assign centroids_valid_out = valid_q;
  assign timeout_out         = timeout_q;

endmodule

// File: tb/tb_kmeans_scheduler.sv
// Self-checking bench for kmeans_scheduler with a short compute timeout.
// Table-driven publish rounds, randomized rounds against a frame-level model, and hand-written corner cases.
// Inputs are driven 1 time unit after the rising edge; outputs are checked a further unit later.
module tb_kmeans_scheduler;

  localparam int TMO = 16;

  logic        clk_in = 1'b0;
  logic        rst_n_in, enable_in, new_frame_in, km_valid_in;
  logic [2:0]  num_balls_in;
  logic [8:0]  seed_x_in [6:0];
  logic [7:0]  seed_y_in [6:0];
  logic [8:0]  km_x_in [6:0];
  logic [7:0]  km_y_in [6:0];
  logic        km_rst_out, km_new_frame_out, centroids_valid_out, timeout_out;
  logic [2:0]  km_num_balls_out;
  logic [8:0]  km_seed_x_out [6:0];
  logic [7:0]  km_seed_y_out [6:0];
  logic [8:0]  centroids_x_out [6:0];
  logic [7:0]  centroids_y_out [6:0];
  logic [15:0] drop_count_out;
  logic [23:0] compute_cycles_out;

  kmeans_scheduler #(.WIDTH(320), .HEIGHT(180), .COMPUTE_TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in), .new_frame_in(new_frame_in),
    .num_balls_in(num_balls_in), .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
    .km_valid_in(km_valid_in), .km_x_in(km_x_in), .km_y_in(km_y_in),
    .km_rst_out(km_rst_out), .km_new_frame_out(km_new_frame_out), .km_num_balls_out(km_num_balls_out),
    .km_seed_x_out(km_seed_x_out), .km_seed_y_out(km_seed_y_out),
    .centroids_x_out(centroids_x_out), .centroids_y_out(centroids_y_out),
    .centroids_valid_out(centroids_valid_out), .timeout_out(timeout_out),
    .drop_count_out(drop_count_out), .compute_cycles_out(compute_cycles_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference: published centroids, current seeds, latched ball count, drop tally.
  int m_cx [7];
  int m_cy [7];
  int m_sx [7];
  int m_sy [7];
  int m_nb;
  bit m_force;
  int m_drop;

  typedef struct {
    int nb;
    int kx [7];
    int ky [7];
    int ex [7];
    int ey [7];
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int exp_drop();
`ifdef KMEANS_SCHED_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_cycles(input int w);
`ifdef KMEANS_SCHED_STATS_EN
    return w;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) begin
      m_cx[i] = 0; m_cy[i] = 0; m_sx[i] = 0; m_sy[i] = 0;
    end
    m_nb = 0; m_force = 1'b1; m_drop = 0;
  endfunction

  function automatic void model_publish();
    for (int i = 0; i < 7; i++) begin
      if (i >= m_nb) begin
        m_cx[i] = 0; m_cy[i] = 0;
      end else if (int'(km_x_in[i]) < 320 && int'(km_y_in[i]) < 180) begin
        m_cx[i] = int'(km_x_in[i]); m_cy[i] = int'(km_y_in[i]);
      end
    end
  endfunction

  function automatic void model_km_rst();
    bit dflt;
    dflt = m_force || (m_nb != int'(num_balls_in));
    for (int i = 0; i < 7; i++) begin
      m_sx[i] = dflt ? int'(seed_x_in[i]) : m_cx[i];
      m_sy[i] = dflt ? int'(seed_y_in[i]) : m_cy[i];
    end
    m_force = 1'b0;
    m_nb    = int'(num_balls_in);
  endfunction

  task automatic randomize_seeds();
    for (int i = 0; i < 7; i++) begin
      seed_x_in[i] = 9'($urandom_range(0, 319));
      seed_y_in[i] = 8'($urandom_range(0, 179));
    end
  endtask

  task automatic check_cents(input string tag);
    for (int i = 0; i < 7; i++) begin
      chk({tag, "_cx"}, 32'(centroids_x_out[i]), m_cx[i]);
      chk({tag, "_cy"}, 32'(centroids_y_out[i]), m_cy[i]);
    end
  endtask

  task automatic check_seeds(input string tag);
    for (int i = 0; i < 7; i++) begin
      chk({tag, "_sx"}, 32'(km_seed_x_out[i]), m_sx[i]);
      chk({tag, "_sy"}, 32'(km_seed_y_out[i]), m_sy[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_km_rst"}, 32'(km_rst_out), 1);
    chk({tag, "_km_nf"}, 32'(km_new_frame_out), 0);
    chk({tag, "_nb"}, 32'(km_num_balls_out), 0);
    chk({tag, "_valid"}, 32'(centroids_valid_out), 0);
    chk({tag, "_timeout"}, 32'(timeout_out), 0);
    chk({tag, "_drop"}, 32'(drop_count_out), 0);
    chk({tag, "_cycles"}, 32'(compute_cycles_out), 0);
    check_cents(tag);
    check_seeds(tag);
  endtask

  // Leaves the DUT in KM_RST; this advances it to SYNC and checks the new seeds.
  task automatic finish_rst(input string tag);
    model_km_rst();
    tick();
    #1;
    chk({tag, "_sync_km_rst"}, 32'(km_rst_out), 0);
    chk({tag, "_sync_valid"}, 32'(centroids_valid_out), 0);
    chk({tag, "_nb_out"}, 32'(km_num_balls_out), m_nb);
    check_seeds(tag);
  endtask

  // From SYNC: first strobe only aligns, second strobe is forwarded and starts COMPUTE.
  task automatic start_frame(input string tag);
    new_frame_in = 1'b1;
    #1 chk({tag, "_nf_sync"}, 32'(km_new_frame_out), 0);
    tick();
    new_frame_in = 1'b0;
    #1 chk({tag, "_nf_store_quiet"}, 32'(km_new_frame_out), 0);
    new_frame_in = 1'b1;
    #1 chk({tag, "_nf_store"}, 32'(km_new_frame_out), 1);
    tick();
    new_frame_in = 1'b0;
  endtask

  // In COMPUTE at count 0: waits w cycles (optionally dropping frames), then delivers a result.
  task automatic compute_valid(input string tag, input int w, input bit drops);
    randomize_seeds();
    #1 check_seeds({tag, "_stable"});
    for (int c = 0; c < w; c++) begin
      new_frame_in = drops && ($urandom_range(0, 3) == 0);
      if (new_frame_in) m_drop++;
      tick();
    end
    new_frame_in = 1'b0;
    km_valid_in  = 1'b1;
    tick();
    km_valid_in = 1'b0;
    model_publish();
    #1;
    chk({tag, "_valid_pulse"}, 32'(centroids_valid_out), 1);
    chk({tag, "_km_rst_after"}, 32'(km_rst_out), 1);
    chk({tag, "_cycles"}, 32'(compute_cycles_out), exp_cycles(w));
    chk({tag, "_drop"}, 32'(drop_count_out), exp_drop());
    check_cents(tag);
  endtask

  initial begin
    tbl[0] = '{nb: 3, kx: '{100, 200, 300, 40, 50, 60, 70}, ky: '{50, 60, 170, 1, 2, 3, 4},
               ex: '{100, 200, 300, 0, 0, 0, 0}, ey: '{50, 60, 170, 0, 0, 0, 0}};
    tbl[1] = '{nb: 3, kx: '{101, 511, 319, 5, 6, 7, 8}, ky: '{51, 61, 180, 1, 1, 1, 1},
               ex: '{101, 200, 300, 0, 0, 0, 0}, ey: '{51, 60, 170, 0, 0, 0, 0}};
    tbl[2] = '{nb: 7, kx: '{320, 10, 20, 30, 40, 50, 60}, ky: '{0, 179, 0, 0, 0, 0, 200},
               ex: '{101, 10, 20, 30, 40, 50, 0}, ey: '{51, 179, 0, 0, 0, 0, 0}};
    tbl[3] = '{nb: 2, kx: '{1, 2, 3, 4, 5, 6, 7}, ky: '{9, 9, 9, 9, 9, 9, 9},
               ex: '{1, 2, 0, 0, 0, 0, 0}, ey: '{9, 9, 0, 0, 0, 0, 0}};

    rst_n_in = 1'b0; enable_in = 1'b0; new_frame_in = 1'b0; km_valid_in = 1'b0; num_balls_in = 3'd0;
    for (int i = 0; i < 7; i++) begin
      seed_x_in[i] = 9'd0; seed_y_in[i] = 8'd0; km_x_in[i] = 9'd0; km_y_in[i] = 8'd0;
    end
    model_reset();

    #12;
    check_reset_vals("por");
    tick();
    rst_n_in = 1'b1;
    tick();
    #1 chk("idle_km_rst", 32'(km_rst_out), 1);

    // Bring-up: km_rst_out held until one cycle after enable, seeds from defaults.
    num_balls_in = 3'(tbl[0].nb);
    randomize_seeds();
    enable_in = 1'b1;
    #1 chk("enable_km_rst", 32'(km_rst_out), 1);
    tick();
    #1 chk("kmrst_state", 32'(km_rst_out), 1);
    finish_rst("bringup");

    // Table rounds: filtering, keep-previous, forced zero, seed source.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) begin
        km_x_in[i] = 9'(tbl[r].kx[i]);
        km_y_in[i] = 8'(tbl[r].ky[i]);
      end
      start_frame($sformatf("tbl%0d", r));
      num_balls_in = 3'((r < 3) ? tbl[r + 1].nb : tbl[3].nb);
      compute_valid($sformatf("tbl%0d", r), $urandom_range(0, 12), 1'b1);
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("tbl%0d_x%0d", r, i), 32'(centroids_x_out[i]), tbl[r].ex[i]);
        chk($sformatf("tbl%0d_y%0d", r, i), 32'(centroids_y_out[i]), tbl[r].ey[i]);
      end
      finish_rst($sformatf("tbl%0d", r));
    end

    // Timeout: no result within TMO cycles; seeds revert to defaults despite unchanged ball count.
    start_frame("tmo");
    randomize_seeds();
    repeat (TMO - 1) tick();
    #1 chk("tmo_not_yet", 32'(timeout_out), 0);
    chk("tmo_still_compute", 32'(km_rst_out), 0);
    tick();
    #1 chk("tmo_set", 32'(timeout_out), 1);
    chk("tmo_km_rst", 32'(km_rst_out), 1);
    chk("tmo_no_valid", 32'(centroids_valid_out), 0);
    check_cents("tmo_keep");
    m_force = 1'b1;
    finish_rst("tmo");

    // Result in the last allowed cycle wins: publish, no forced default seeds next time.
    for (int i = 0; i < 7; i++) begin
      km_x_in[i] = 9'($urandom_range(0, 319));
      km_y_in[i] = 8'($urandom_range(0, 179));
    end
    start_frame("race");
    compute_valid("race", TMO - 1, 1'b0);
    chk("race_timeout_sticky", 32'(timeout_out), 1);
    finish_rst("race");

    // Randomized rounds against the model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 7; i++) begin
        km_x_in[i] = 9'($urandom_range(0, 511));
        km_y_in[i] = 8'($urandom_range(0, 255));
      end
      start_frame($sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) num_balls_in = 3'($urandom_range(1, 7));
      compute_valid($sformatf("rnd%0d", r), $urandom_range(0, 12), 1'b1);
      finish_rst($sformatf("rnd%0d", r));
    end

    // Enable dropped mid-compute: honoured only at exit, returns to IDLE.
    start_frame("dis");
    enable_in = 1'b0;
    compute_valid("dis", 3, 1'b0);
    tick();
    #1 chk("dis_idle_km_rst", 32'(km_rst_out), 1);
    chk("dis_idle_valid", 32'(centroids_valid_out), 0);
    enable_in = 1'b1;
    tick();
    #1 chk("dis_rearm_km_rst", 32'(km_rst_out), 1);
    finish_rst("dis");

    // Enable dropped in SYNC: immediate return to IDLE.
    enable_in = 1'b0;
    tick();
    #1 chk("sync_dis_km_rst", 32'(km_rst_out), 1);
    enable_in = 1'b1;
    tick();
    finish_rst("sync_dis");

    // Asynchronous reset mid-compute.
    start_frame("arst");
    repeat (3) tick();
    rst_n_in = 1'b0;
    model_reset();
    #1 check_reset_vals("arst");
    tick();
    rst_n_in = 1'b1;
    tick();
    #1 chk("arst_kmrst", 32'(km_rst_out), 1);
    finish_rst("arst");

    // Exactly two dropped frames after a fresh reset.
    start_frame("drop2");
    new_frame_in = 1'b1; tick();
    new_frame_in = 1'b0; tick();
    new_frame_in = 1'b1; tick();
    new_frame_in = 1'b0;
    m_drop = 2;
    #1 chk("drop2_count", 32'(drop_count_out), exp_drop());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
